// File: rtl/score_display_pkg.sv
// score_display_pkg: shared types and segment
// patterns for the two-digit score display.
package score_display_pkg;

  typedef enum logic {
    LIVE  = 1'b0,
    FLASH = 1'b1
  } disp_state_t;

  // Active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/score_display_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to seven-segment
// decoder; non-decimal codes show a dash.
module bcd_to_seg
  import score_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Digit lookup, 10..15 fall through to a dash
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// score_display: multiplexed two-digit display
// with end-of-game flash of the final score.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 10000,
  parameter int FLASH_HALF  = 2500000,
  parameter int FLASH_COUNT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic       isGameComplete,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       flashing
);

  localparam int RW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW =
    (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int PW =
    (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  disp_state_t   state_q;
  logic [7:0]    sh_q;
  logic          gc_q;
  logic [HW-1:0] half_q;
  logic [PW-1:0] phase_q;
  logic [RW-1:0] ref_q;
  logic          sel_q;

  logic       rise;
  logic [3:0] dig;
  logic [6:0] dec_seg;
  logic [6:0] seg_d;
  logic [1:0] en_d;
  logic       blank;

  assign rise = isGameComplete & ~gc_q;

  // Pick the digit the multiplexer is showing
  always_comb begin
    dig = sel_q ? sh_q[7:4] : sh_q[3:0];
  end

  bcd_to_seg u_dec (
    .bcd_i (dig),
    .seg_o (dec_seg)
  );

  // Blank a leading-zero tens digit or a flash off phase
  always_comb begin
    blank = (sel_q && (sh_q[7:4] == 4'd0))
         || ((state_q == FLASH) && phase_q[0]);
    seg_d = dec_seg;
    en_d  = sel_q ? 2'b10 : 2'b01;
    if (blank) begin
      seg_d = SEG_OFF;
      en_d  = 2'b00;
    end
  end

  // Free-running digit multiplex timer
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      sel_q <= 1'b0;
    end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      sel_q <= ~sel_q;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  // Live/flash control, shadow capture, output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LIVE;
      sh_q     <= '0;
      gc_q     <= 1'b0;
      half_q   <= '0;
      phase_q  <= '0;
      seg      <= SEG_OFF;
      digit_en <= 2'b00;
      flashing <= 1'b0;
    end else begin
      gc_q     <= isGameComplete;
      seg      <= seg_d;
      digit_en <= en_d;
      flashing <= (state_q == FLASH);
      unique case (state_q)
        LIVE: begin
          if (rise) begin
            state_q <= FLASH;
            half_q  <= '0;
            phase_q <= '0;
          end else begin
            sh_q <= {bcd_tens, bcd_ones};
          end
        end
        FLASH: begin
          if (!isGameComplete) begin
            state_q <= LIVE;
          end else if (half_q == HW'(FLASH_HALF - 1)) begin
            half_q <= '0;
            if (phase_q == PW'(FLASH_COUNT - 1)) begin
              phase_q <= '0;
              state_q <= LIVE;
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end else begin
            half_q <= half_q + 1'b1;
          end
        end
        default: state_q <= LIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed vectors for the
// score display with small timing parameters.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd_ones = 4'd0;
  logic [3:0] bcd_tens = 4'd0;
  logic       gc = 1'b0;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       flashing;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  score_display #(
    .REFRESH_DIV (4),
    .FLASH_HALF  (8),
    .FLASH_COUNT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bcd_ones       (bcd_ones),
    .bcd_tens       (bcd_tens),
    .isGameComplete (gc),
    .seg            (seg),
    .digit_en       (digit_en),
    .flashing       (flashing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg_o;
    logic [1:0] en_t;
    logic [6:0] seg_t;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check(input string nm,
                       input logic [1:0] e_en,
                       input logic [6:0] e_seg,
                       input logic e_fl);
    n_cmp = n_cmp + 1;
    if (digit_en !== e_en || seg !== e_seg
        || flashing !== e_fl) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cyc=%0d: got en=%b seg=%h fl=%b want en=%b seg=%h fl=%b",
               nm, cyc, digit_en, seg, flashing,
               e_en, e_seg, e_fl);
    end
  endtask

  // Output after edge cyc shows sel from the edge before
  function automatic logic tens_phase();
    return 1'(((cyc - 1) >> 2) & 1);
  endfunction

  task automatic check_mux(input string nm,
                           input logic [6:0] s_o,
                           input logic [1:0] e_t,
                           input logic [6:0] s_t,
                           input logic fl);
    if (tens_phase())
      check(nm, e_t, s_t, fl);
    else
      check(nm, 2'b01, s_o, fl);
  endtask

  initial begin
    vecs[0] = '{4'd0, 4'd7,  7'h07, 2'b00, 7'h00};
    vecs[1] = '{4'd4, 4'd2,  7'h5B, 2'b10, 7'h66};
    vecs[2] = '{4'd0, 4'd12, 7'h40, 2'b00, 7'h00};
    vecs[3] = '{4'd9, 4'd0,  7'h3F, 2'b10, 7'h6F};
    vecs[4] = '{4'd15, 4'd8, 7'h7F, 2'b10, 7'h40};
    vecs[5] = '{4'd0, 4'd0,  7'h3F, 2'b00, 7'h00};

    // Reset state
    tick();
    tick();
    check("reset", 2'b00, 7'h00, 1'b0);
    rst = 1'b0;
    cyc = 0;
    tick();
    check("first_after_reset", 2'b01, 7'h3F, 1'b0);

    // Live decode vectors
    for (int v = 0; v < 6; v++) begin
      bcd_tens = vecs[v].tens;
      bcd_ones = vecs[v].ones;
      tick();
      tick();
      for (int k = 0; k < 8; k++) begin
        tick();
        check_mux($sformatf("live_v%0d", v),
                  vecs[v].seg_o, vecs[v].en_t,
                  vecs[v].seg_t, 1'b0);
      end
    end

    // Full flash: 23 frozen, inputs jump to 45
    bcd_tens = 4'd2;
    bcd_ones = 4'd3;
    tick();
    tick();
    bcd_tens = 4'd4;
    bcd_ones = 4'd5;
    gc = 1'b1;
    tick();
    for (int m = 1; m <= 32; m++) begin
      tick();
      if ((((m - 1) >> 3) & 1) == 1)
        check($sformatf("flash_off_%0d", m),
              2'b00, 7'h00, 1'b1);
      else
        check_mux($sformatf("flash_on_%0d", m),
                  7'h4F, 2'b10, 7'h5B, 1'b1);
    end
    tick();
    check_mux("flash_end", 7'h4F, 2'b10, 7'h5B, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_mux("high_score", 7'h6D, 2'b10, 7'h66, 1'b0);
    end

    // Second pulse needs gc low first
    gc = 1'b0;
    bcd_tens = 4'd6;
    bcd_ones = 4'd1;
    tick();
    tick();
    tick();
    check_mux("pre_abort", 7'h06, 2'b10, 7'h7D, 1'b0);

    // Abort: drop gc at cycle 10 of flash
    bcd_tens = 4'd8;
    bcd_ones = 4'd8;
    gc = 1'b1;
    tick();
    for (int m = 1; m <= 10; m++) begin
      tick();
      if (m > 8)
        check($sformatf("abort_off_%0d", m),
              2'b00, 7'h00, 1'b1);
      else
        check_mux($sformatf("abort_on_%0d", m),
                  7'h06, 2'b10, 7'h7D, 1'b1);
    end
    gc = 1'b0;
    tick();
    check("abort_last_flash", 2'b00, 7'h00, 1'b1);
    tick();
    check_mux("abort_live", 7'h06, 2'b10, 7'h7D, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_mux("abort_new", 7'h7F, 2'b10, 7'h7F, 1'b0);
    end

    // Reset in the middle of a flash
    gc = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_mux("mid_flash", 7'h7F, 2'b10, 7'h7F, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_flash", 2'b00, 7'h00, 1'b0);
    rst = 1'b0;
    gc = 1'b0;
    cyc = 0;
    tick();
    check("after_rst_flash", 2'b01, 7'h3F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Drives a two-digit multiplexed common-cathode seven-segment display from the score tracker's `bcd_ones`/`bcd_tens`/`isGameComplete` outputs. It is the display end of the score interface. It time-multiplexes the two digits and blanks the tens digit when it is a leading zero. When a game ends, it freezes and flashes the final current score for a fixed number of blinks, then shows the live high score. It sits between the score tracker and the board's segment and digit-enable pins.

## Interface
- `REFRESH_DIV`, 10000: clock cycles each digit stays enabled before the multiplexer switches to the other digit; must be ≥2.
- `FLASH_HALF`, 2500000: clock cycles per flash half-period (one on phase or one off phase); must be ≥1.
- `FLASH_COUNT`, 6: number of flash half-periods after a game ends; even, ≥2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `bcd_ones`  in  4  ones digit from the score tracker.
- `bcd_tens`  in  4  tens digit from the score tracker.
- `isGameComplete`  in  1  game-over level from the score tracker.
- `seg`  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- `digit_en`  out  2  one-hot digit enable: bit 0 is ones, bit 1 is tens; `00` means blank.
- `flashing`  out  1  high while state is FLASH.

## Operation
- Shadow register `{sh_tens, sh_ones}` (8 bits) supplies what is displayed.
- In LIVE state, the shadow loads `{bcd_tens, bcd_ones}` every cycle, except in the cycle where a rising edge of `isGameComplete` is detected.
- At that rising edge the tracker has already switched its BCD outputs to the high score. The shadow therefore keeps the previous cycle's value, which is the final current score.
- Rising edge: `isGameComplete`=1 and its registered copy `gc_q`=0.
- States:
  - LIVE: shows the shadow, which follows the inputs. On a rising edge, go to FLASH; clear `half_cnt` and `phase_cnt`.
  - FLASH: shadow frozen. Odd `phase_cnt` means off (`digit_en`=00, `seg`=0); even `phase_cnt` means on. The first phase is on.
    - `half_cnt` counts 0..FLASH_HALF-1. At its terminal value, `phase_cnt` increments.
    - When `phase_cnt` reaches FLASH_COUNT, go to LIVE; the shadow reloads on the next cycle and shows the high score.
    - If `isGameComplete` falls while in FLASH (a new game has started), go to LIVE in the next cycle.
- Multiplexer:
  - `ref_cnt` counts 0..REFRESH_DIV-1; at its terminal value, `sel` toggles.
  - `ref_cnt` and `sel` run freely in every state.
  - `sel`=0 drives the ones digit; `sel`=1 drives the tens digit.
- Tens blanking: when `sel`=1 and `sh_tens`==0, output `digit_en`=00 and `seg`=0. The ones digit is never blanked, so a score of 0 shows "0".
- Decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10–15 shows a dash, 40 (`g` only).
- Counter widths: `$clog2` of the corresponding parameter, minimum 1. The counters never wrap past their terminal values.

## Timing
- Reset values: `seg`=0, `digit_en`=00, `flashing`=0, state=LIVE, shadow=0, `sel`=0, all counters 0, `gc_q`=0.
- `seg`, `digit_en` and `flashing` are registered. Outputs reflect the shadow, `sel` and state one cycle later.
- In the first cycle after `rst` falls, outputs are `digit_en`=01 and `seg`=3F.
- Input to output latency in LIVE is 2 cycles: one for the shadow, one for the output register.
- `flashing` rises 1 cycle after the rising-edge cycle. It falls 1 cycle after the transition back to LIVE.
- FLASH lasts FLASH_HALF×FLASH_COUNT cycles if not aborted.
- `rst` asserted in any state returns every register to its reset value on the next edge; an in-progress flash sequence is discarded.
- If `isGameComplete` pulses again while in FLASH, the flash sequence does not restart.

## Structure
- Package `score_display_pkg`:
  - state enum `disp_state_t` {LIVE, FLASH};
  - segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF`.
- Sub-module `bcd_to_seg`: purely combinational decoder, 4-bit input to 7-bit output. It is instantiated once and fed by the selected shadow digit.

## Test plan
All scenarios use `REFRESH_DIV`=4, `FLASH_HALF`=8, `FLASH_COUNT`=4.
- Reset, then hold inputs `tens`=0, `ones`=7 → `digit_en` alternates 01 (`seg`=07) for 4 cycles and 00 (tens blanked) for 4 cycles.
- Inputs `tens`=4, `ones`=2 → ones phase shows `seg`=5B with `digit_en`=01; tens phase shows `seg`=66 with `digit_en`=10.
- Inputs 2/3, then in the same cycle switch to 4/5 and raise `isGameComplete` → `flashing`=1 and "23" is shown for 8 cycles, blank for 8, "23" for 8, blank for 8. Then `flashing`=0 and "45" is shown from 2 cycles later.
- Drop `isGameComplete` at cycle 10 of FLASH → LIVE on the next cycle; live inputs are shown within 2 cycles.
- Input `ones`=12 → `seg`=40 in the ones phase.
- Assert `rst` mid-FLASH → next cycle all outputs are 0 and state is LIVE; the following cycle shows `digit_en`=01, `seg`=3F.
